pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Multi-channel, parametrised successor to the team's single-channel 11-bit PWM generator. Drives the H-bridge gates for the balance-platform motors.
- CH channels share one W-bit timebase. The timebase supports edge-aligned or center-aligned counting.
- Each channel has a double-buffered duty register and a complementary low-side output.
- Period, mode and duty change only at a period boundary, so a motor never sees a glitched pulse.

Parameters:
CH, 2, number of PWM channels
W, 11, counter/period/duty width in bits
DT_W, 6, dead-time count width

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  reset
en  input  1  run enable; low = idle
period  input  W  period in timebase ticks, P
center  input  1  0 = edge-aligned, 1 = center-aligned
duty_in  input  CH*W  packed duty values, channel i at bits [i*W +: W]
duty_ld  input  1  one-clk strobe; captures all of duty_in into the pending registers
deadtime  input  DT_W  dead-time in clocks (used only with the optional feature)
pwm_hi  output  CH  high-side drive per channel
pwm_lo  output  CH  low-side drive per channel
cycle_start  output  1  one-clk pulse marking the start of each PWM period

Behaviour:
- Reset: asynchronous, active-low on rst_n; clock clk. Reset clears:
  - cnt to 0 and counting direction to up;
  - pending duty, active duty, active period and active mode to 0;
  - pwm_hi, pwm_lo and cycle_start to 0.
  Reset asserted mid-period forces all outputs low within the same cycle. This is asynchronous, not clock-waited.
- Idle: en=0, or active period=0.
  - cnt is held at 0 with direction up; all outputs are 0.
  - Active period and mode reload from the inputs every clock while idle.
- Boundary: the cycle in which cnt=0 while counting up, including the first cycle after leaving idle. At each boundary:
  - active period <= period;
  - active mode <= center;
  - active duty <= pending duty.
  If duty_ld coincides with a boundary, the new duty_in goes straight to active (bypass) and is also written to pending.
- Edge mode: cnt runs 0,1,…,P-1 and wraps to 0. The period is P clocks.
- Center mode: cnt runs 0,1,…,P-1, then P-1,…,1,0, then up again.
  - Each turning-point value is repeated once.
  - The period is 2P clocks; direction flips after the repeated value.
- Compare: raw_i = (cnt < active duty_i), an unsigned W-bit comparison.
  - Edge mode: high time is min(duty,P) clocks.
  - Center mode: high time is 2*min(duty,P) clocks, symmetric about the boundary.
  - duty=0 gives constant low; duty>=P gives constant high with no glitch at the wrap.
- Latency: outputs are registered, one clk after the cnt value they reflect.
  - cycle_start pulses in the same cycle that pwm shows the compare result for boundary cnt=0.
- duty_ld outside a boundary updates pending only; it never affects the current period.
- Dropping en mid-period: the next clk goes to idle and the outputs go low. Raising en again starts a fresh period with a boundary.
- Changes to period or center mid-period have no effect until the next boundary.

Optional Feature:
PWM_DEADTIME_EN
- Defined:
  - Each raw_i transition forces both pwm_hi[i] and pwm_lo[i] to 0 for `deadtime` clks.
  - After the gap, the side matching the new raw_i level asserts.
  - If raw_i toggles back before the gap expires, the gap restarts and neither side asserts.
  - deadtime=0 behaves exactly like the undefined case.
  - One DT_W-bit down-counter per channel.
- Undefined:
  - pwm_lo[i] = ~pwm_hi[i] whenever running (both 0 in idle and reset); the deadtime port is ignored.
- pwm_hi and pwm_lo are never both 1, in either build.

Test Plan:
1. Edge mode, P=10, duty0=3, duty1=7 -> pwm_hi = 3/10 and 7/10 high, repeating; cycle_start every 10 clks; pwm_lo is the complement.
2. Center mode, P=8, duty0=2 -> 16-clk period; pwm_hi high for 2 clks before and 2 clks after each cycle_start, 4 total.
3. duty_ld with duty0=5 mid-period, while the current value is 2 -> current period keeps 2, next period shows 5. Repeat with duty_ld on the boundary cycle -> 5 applies immediately.
4. Saturation: duty0=0 -> pwm_hi constantly 0; duty0=12 with P=10 -> constantly 1, no low pulse at the wrap.
5. PWM_DEADTIME_EN, deadtime=3, P=20, duty=8 -> 3-clk both-low gap at each edge; hi high 5 clks, lo high 9 clks. With duty=2 -> hi never asserts.
6. rst_n pulled low mid-period -> all outputs 0 immediately. After release with en=1 -> cycle_start on the first running cycle. en=0 mid-period -> outputs 0 on the next clk.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared edge/center-aligned timebase
//
// Purpose: CH PWM channels on one W-bit timebase, double-buffered duty,
// complementary low-side outputs. Period, mode and duty are latched only at
// the period boundary (cnt=0 while counting up).
// Optional build macro: PWM_DEADTIME_EN adds a per-channel dead-time gap.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             run enable (low = idle, outputs low)
//   period         period in timebase ticks
//   center         0 = edge-aligned, 1 = center-aligned
//   duty_in        packed duties, channel i at [i*W +: W]
//   duty_ld        strobe capturing duty_in into the pending registers
//   deadtime       dead-time in clocks (PWM_DEADTIME_EN only)
//   pwm_hi/pwm_lo  high/low-side drive per channel
//   cycle_start    one-clk pulse aligned with the boundary compare result
`timescale 1ns/1ps
module pwm_multi #(
    parameter int CH   = 2,
    parameter int W    = 11,
    parameter int DT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [W-1:0]    period,
    input  logic            center,
    input  logic [CH*W-1:0] duty_in,
    input  logic            duty_ld,
    input  logic [DT_W-1:0] deadtime,
    output logic [CH-1:0]   pwm_hi,
    output logic [CH-1:0]   pwm_lo,
    output logic            cycle_start
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [W-1:0]    cnt_q, cnt_d;
    dir_e            dir_q, dir_d;
    logic [CH*W-1:0] pend_q, pend_d;
    logic [CH*W-1:0] duty_q, duty_d;
    logic [W-1:0]    per_q, per_d;
    logic            mode_q, mode_d;
    logic [CH-1:0]   hi_q, hi_d;
    logic [CH-1:0]   lo_q, lo_d;
    logic            cs_q, cs_d;

    logic            running;
    logic            boundary;
    logic [W-1:0]    eff_p;
    logic            eff_m;
    logic [CH*W-1:0] eff_duty;
    logic [CH-1:0]   raw;

`ifdef PWM_DEADTIME_EN
    logic [CH*DT_W-1:0] dt_q, dt_d;
    logic [CH-1:0]      rprev_q, rprev_d;
`else
    wire unused_deadtime = ^deadtime;
`endif

    always_comb begin
        running  = en && (per_q != '0);
        boundary = running && (cnt_q == '0) && (dir_q == DIR_UP);

        // At the boundary the freshly latched values already govern this
        // cycle's compare and count step, so a bypassed duty_ld is immediate.
        eff_p    = boundary ? period : per_q;
        eff_m    = boundary ? center : mode_q;
        eff_duty = boundary ? (duty_ld ? duty_in : pend_q) : duty_q;

        pend_d = duty_ld ? duty_in : pend_q;
        per_d  = (!running || boundary) ? period : per_q;
        mode_d = (!running || boundary) ? center : mode_q;
        duty_d = eff_duty;

        cnt_d = '0;
        dir_d = DIR_UP;
        if (running) begin
            if (!eff_m) begin
                cnt_d = (cnt_q == eff_p - 1'b1) ? '0 : cnt_q + 1'b1;
            end else if (dir_q == DIR_UP) begin
                // Top value is held for one extra clock before turning down.
                if (cnt_q == eff_p - 1'b1) begin
                    cnt_d = cnt_q;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = DIR_DOWN;
                end
            end
        end

        for (int i = 0; i < CH; i++) begin
            raw[i] = (cnt_q < eff_duty[i*W +: W]);
        end

        cs_d = boundary;

`ifdef PWM_DEADTIME_EN
        hi_d    = '0;
        lo_d    = '0;
        dt_d    = '0;
        rprev_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (running) begin
                rprev_d[i] = raw[i];
                if (raw[i] != rprev_q[i]) begin
                    // Any edge (re)starts the gap; deadtime=0 means no gap.
                    if (deadtime != '0) begin
                        dt_d[i*DT_W +: DT_W] = deadtime - 1'b1;
                    end else begin
                        hi_d[i] = raw[i];
                        lo_d[i] = ~raw[i];
                    end
                end else if (dt_q[i*DT_W +: DT_W] != '0) begin
                    dt_d[i*DT_W +: DT_W] = dt_q[i*DT_W +: DT_W] - 1'b1;
                end else begin
                    hi_d[i] = raw[i];
                    lo_d[i] = ~raw[i];
                end
            end
        end
`else
        hi_d = running ? raw : '0;
        lo_d = running ? ~raw : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= '0;
            duty_q  <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cs_q    <= 1'b0;
`ifdef PWM_DEADTIME_EN
            dt_q    <= '0;
            rprev_q <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            duty_q  <= duty_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cs_q    <= cs_d;
`ifdef PWM_DEADTIME_EN
            dt_q    <= dt_d;
            rprev_q <= rprev_d;
`endif
        end
    end

    assign pwm_hi      = hi_q;
    assign pwm_lo      = lo_q;
    assign cycle_start = cs_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi
`timescale 1ns/1ps
module tb_pwm_multi;

    localparam int CH   = 2;
    localparam int W    = 11;
    localparam int DT_W = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [W-1:0]    period;
    logic            center;
    logic [CH*W-1:0] duty_in;
    logic            duty_ld;
    logic [DT_W-1:0] deadtime;
    logic [CH-1:0]   pwm_hi;
    logic [CH-1:0]   pwm_lo;
    logic            cycle_start;

    int tests = 0;
    int fails = 0;

    pwm_multi #(.CH(CH), .W(W), .DT_W(DT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .center(center),
        .duty_in(duty_in), .duty_ld(duty_ld), .deadtime(deadtime),
        .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .cycle_start(cycle_start)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: position k within the current period; the counter
    // value is derived arithmetically from k, period and mode.
    int          m_per, m_k, m_len, cv;
    bit          m_mode;
    int          m_duty [CH];
    int          m_pend [CH];
    bit [63:0]   hist [CH];
    bit [63:0]   mask;
    bit          run;
    bit [CH-1:0] m_raw;
    bit [CH-1:0] exp_hi, exp_lo;
    bit          exp_cs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_per = 0; m_mode = 0; m_k = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty[i] = 0; m_pend[i] = 0; hist[i] = '0;
            end
            exp_hi = '0; exp_lo = '0; exp_cs = 0;
        end else begin
            run    = en && (m_per != 0);
            m_raw  = '0;
            exp_cs = 0;
            if (!run) begin
                m_per  = int'(period);
                m_mode = center;
                m_k    = 0;
            end else begin
                if (m_k == 0) begin
                    m_per  = int'(period);
                    m_mode = center;
                    for (int i = 0; i < CH; i++)
                        m_duty[i] = duty_ld ? int'(duty_in[i*W +: W]) : m_pend[i];
                    exp_cs = 1;
                end
                cv = (m_mode && m_k >= m_per) ? 2*m_per - 1 - m_k : m_k;
                for (int i = 0; i < CH; i++) m_raw[i] = (cv < m_duty[i]);
                m_len = m_mode ? 2*m_per : m_per;
                m_k++;
                if (m_k >= m_len) m_k = 0;
            end
            if (duty_ld)
                for (int i = 0; i < CH; i++) m_pend[i] = int'(duty_in[i*W +: W]);
`ifdef PWM_DEADTIME_EN
            // A side drives only once raw has held its level for deadtime+1
            // consecutive compare cycles (idle counts as low).
            mask = (int'(deadtime) >= 63) ? '1 : (64'd1 << (int'(deadtime) + 1)) - 64'd1;
            for (int i = 0; i < CH; i++) begin
                hist[i]   = {hist[i][62:0], m_raw[i]};
                exp_hi[i] = run && ((hist[i] & mask) == mask);
                exp_lo[i] = run && ((hist[i] & mask) == 64'd0);
            end
`else
            mask = '0;
            for (int i = 0; i < CH; i++) begin
                hist[i]   = '0;
                exp_hi[i] = run && m_raw[i];
                exp_lo[i] = run && !m_raw[i];
            end
`endif
        end
    end

    always @(negedge clk) begin
        chk("cycle_outputs", int'({pwm_hi, pwm_lo, cycle_start}),
            int'({exp_hi, exp_lo, exp_cs}));
        if ((pwm_hi & pwm_lo) != '0) chk("hi_lo_overlap", int'(pwm_hi & pwm_lo), 0);
    end

    task automatic measure(input int n, output int h0, output int h1,
                           output int l0, output int cs);
        h0 = 0; h1 = 0; l0 = 0; cs = 0;
        for (int k = 0; k < n; k++) begin
            h0 += int'(pwm_hi[0]);
            h1 += int'(pwm_hi[1]);
            l0 += int'(pwm_lo[0]);
            cs += int'(cycle_start);
            @(negedge clk);
        end
    endtask

    task automatic wait_cs(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            if (cycle_start) break;
            @(negedge clk);
        end
        if (k == 100) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic load(input int d0, input int d1);
        duty_in = {W'(d1), W'(d0)};
        duty_ld = 1'b1;
        @(negedge clk);
        duty_ld = 1'b0;
    endtask

    int h0, h1, l0, cs;

    initial begin
        rst_n = 0; en = 0; period = '0; center = 0;
        duty_in = '0; duty_ld = 0; deadtime = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({pwm_hi, pwm_lo, cycle_start}), 0);
        rst_n = 1;

        // Edge mode, P=10, duties 3 and 7
        period = W'(10); center = 0;
        load(3, 7);
        en = 1;
        repeat (25) @(negedge clk);
        measure(10, h0, h1, l0, cs);
        chk("edge_hi0", h0, 3);
        chk("edge_hi1", h1, 7);
        chk("edge_lo0", l0, 7);
        chk("edge_cs", cs, 1);

        // Center mode, P=8, duty0=2
        center = 1; period = W'(8);
        load(2, 0);
        repeat (40) @(negedge clk);
        measure(16, h0, h1, l0, cs);
        chk("center_hi0", h0, 4);
        chk("center_lo0", l0, 12);
        chk("center_cs", cs, 1);
        wait_cs("center");
        chk("center_hi_at_cs", int'(pwm_hi[0]), 1);

        // duty_ld mid-period, then on the boundary cycle
        center = 0; period = W'(10);
        load(2, 0);
        repeat (40) @(negedge clk);
        wait_cs("ld");
        h0 = 0;
        for (int k = 0; k < 10; k++) begin
            h0 += int'(pwm_hi[0]);
            if (k == 0) begin duty_in = {W'(0), W'(5)}; duty_ld = 1; end
            else duty_ld = 0;
            @(negedge clk);
        end
        chk("ld_mid_keep", h0, 2);
        chk("ld_align", int'(cycle_start), 1);
        h0 = 0;
        for (int k = 0; k < 10; k++) begin
            h0 += int'(pwm_hi[0]);
            if (k == 9) begin duty_in = {W'(0), W'(7)}; duty_ld = 1; end
            else duty_ld = 0;
            @(negedge clk);
        end
        chk("ld_mid_next", h0, 5);
        duty_ld = 0;
        measure(10, h0, h1, l0, cs);
        chk("ld_bypass", h0, 7);

        // Saturation
        load(0, 0);
        repeat (25) @(negedge clk);
        measure(20, h0, h1, l0, cs);
        chk("sat_zero_hi", h0, 0);
        load(12, 0);
        repeat (25) @(negedge clk);
        measure(20, h0, h1, l0, cs);
        chk("sat_full_hi", h0, 20);
        chk("sat_full_lo", l0, 0);

`ifdef PWM_DEADTIME_EN
        deadtime = DT_W'(3); period = W'(20);
        load(8, 2);
        repeat (45) @(negedge clk);
        measure(20, h0, h1, l0, cs);
        chk("dt_hi0", h0, 5);
        chk("dt_lo0", l0, 9);
        chk("dt_hi1", h1, 0);
        deadtime = '0; period = W'(10);
`endif

        // Asynchronous reset mid-period, restart, en drop
        load(5, 0);
        repeat (13) @(negedge clk);
        #2 rst_n = 0;
        #1 chk("async_reset", int'({pwm_hi, pwm_lo, cycle_start}), 0);
        @(negedge clk);
        rst_n = 1;
        duty_in = {W'(0), W'(5)}; duty_ld = 1;
        @(negedge clk);
        duty_ld = 0;
        chk("restart_cs_early", int'(cycle_start), 0);
        @(negedge clk);
        chk("restart_cs", int'(cycle_start), 1);
        chk("restart_hi0", int'(pwm_hi[0]), 1);
        repeat (4) @(negedge clk);
        en = 0;
        @(negedge clk);
        chk("en_drop", int'({pwm_hi, pwm_lo, cycle_start}), 0);

        // Randomized run against the model
        en = 1;
`ifdef PWM_DEADTIME_EN
        deadtime = DT_W'($urandom_range(0, 4));
`endif
        for (int n = 0; n < 3000; n++) begin
            duty_ld = ($urandom_range(0, 7) == 0);
            if (duty_ld)
                duty_in = {W'($urandom_range(0, 25)), W'($urandom_range(0, 25))};
            if ($urandom_range(0, 60) == 0) period = W'($urandom_range(1, 20));
            if ($urandom_range(0, 80) == 0) center = ~center;
            if ($urandom_range(0, 150) == 0) en = ~en;
            @(negedge clk);
        end
        duty_ld = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
